// File: rtl/input_port_ctrl_if.sv
// Link bundle between an input port controller and its upstream link, route stage and switch.
// INPUT_PORT_DROP_CNT_EN adds the drop_cnt observation signal.
interface input_port_ctrl_if #(parameter int FLIT_W = 8);
   logic [FLIT_W-1:0] flit_in;
   logic              flit_in_valid;
   logic              credit_out;
   logic [FLIT_W-1:0] route_flit;
   logic [3:0]        port_num_in;
   logic [4:0]        req_out;
   logic              grant_in;
   logic [FLIT_W-1:0] flit_out;
   logic              flit_out_valid;
`ifdef INPUT_PORT_DROP_CNT_EN
   logic [7:0]        drop_cnt;

   modport master (
      output flit_in, flit_in_valid, port_num_in, grant_in,
      input  credit_out, route_flit, req_out, flit_out, flit_out_valid, drop_cnt
   );
   modport slave (
      input  flit_in, flit_in_valid, port_num_in, grant_in,
      output credit_out, route_flit, req_out, flit_out, flit_out_valid, drop_cnt
   );
`else
   modport master (
      output flit_in, flit_in_valid, port_num_in, grant_in,
      input  credit_out, route_flit, req_out, flit_out, flit_out_valid
   );
   modport slave (
      input  flit_in, flit_in_valid, port_num_in, grant_in,
      output credit_out, route_flit, req_out, flit_out, flit_out_valid
   );
`endif
endinterface

// File: rtl/input_port_ctrl.sv
// Router input port: flit FIFO, route lookup and switch request FSM with credit return.
// INPUT_PORT_DROP_CNT_EN adds a saturating count of discarded flits on drop_cnt.
//
// state  | meaning
// IDLE   | waiting for a head flit; non-header heads are discarded
// ROUTE  | header presented on route_flit, route code latched on exit
// ACTIVE | requesting the switch, forwarding flits on grant
// DRAIN  | unroutable packet, popping flits until its last one
module input_port_ctrl #(
   parameter int DEPTH  = 4,
   parameter int FLIT_W = 8
) (
   input logic              clk,
   input logic              rst_n,
   input_port_ctrl_if.slave bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [PTR_W:0]    count;
   logic [3:0]        route_reg;
   logic [FLIT_W-1:0] flit_out_q;
   logic              flit_out_valid_q, credit_q;
   logic              pop, fwd, push, empty, full;
   logic [FLIT_W-1:0] head;
   logic [1:0]        head_type;
   logic              head_start, head_last;
   logic [4:0]        req_dec;

   assign head       = mem[rd_ptr];
   assign head_type  = head[FLIT_W-1 -: 2];
   // header (10) and single (11) open a packet; tail (01) and single (11) close it
   assign head_start = head_type[1];
   assign head_last  = head_type[0];
   assign empty      = (count == '0);
   assign full       = (count == DEPTH_C);
   assign push       = bus.flit_in_valid && (!full || pop);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      fwd       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               if (head_start) state_nxt = ROUTE;
               else            pop = 1'b1;
            end
         end
         ROUTE: begin
            state_nxt = (bus.port_num_in >= 4'd1 && bus.port_num_in <= 4'd5) ? ACTIVE : DRAIN;
         end
         ACTIVE: begin
            if (bus.grant_in && !empty) begin
               pop = 1'b1;
               fwd = 1'b1;
               if (head_last) state_nxt = IDLE;
            end
         end
         DRAIN: begin
            if (!empty) begin
               pop = 1'b1;
               if (head_last) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         rd_ptr           <= '0;
         wr_ptr           <= '0;
         count            <= '0;
         route_reg        <= '0;
         flit_out_q       <= '0;
         flit_out_valid_q <= 1'b0;
         credit_q         <= 1'b0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (state == ROUTE) route_reg <= bus.port_num_in;
         flit_out_valid_q <= fwd;
         if (fwd) flit_out_q <= head;
         credit_q <= pop;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.flit_in;
   end

   always_comb begin
      req_dec = '0;
      if (state == ACTIVE) begin
         case (route_reg)
            4'd1:    req_dec = 5'b00001;
            4'd2:    req_dec = 5'b00010;
            4'd3:    req_dec = 5'b10000;
            4'd4:    req_dec = 5'b00100;
            4'd5:    req_dec = 5'b01000;
            default: req_dec = '0;
         endcase
      end
   end

   assign bus.req_out        = req_dec;
   assign bus.route_flit     = (state == ROUTE) ? head : '0;
   assign bus.flit_out       = flit_out_q;
   assign bus.flit_out_valid = flit_out_valid_q;
   assign bus.credit_out     = credit_q;

`ifdef INPUT_PORT_DROP_CNT_EN
   logic       drop;
   logic [7:0] drop_cnt_q;

   assign drop = pop && (state != ACTIVE);

   always_ff @(posedge clk) begin
      if (!rst_n)                          drop_cnt_q <= '0;
      else if (drop && drop_cnt_q != 8'hff) drop_cnt_q <= drop_cnt_q + 1'b1;
   end

   assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_input_port_ctrl.sv
// Bench for input_port_ctrl: directed scenarios then random traffic against a packet-level model.
// Build with INPUT_PORT_DROP_CNT_EN to also check drop_cnt.
module tb_input_port_ctrl;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n;

   input_port_ctrl_if #(.FLIT_W(8)) bus ();

   input_port_ctrl #(.DEPTH(DEPTH), .FLIT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // packet-level model: buffered flits plus what the port is doing with the current packet
   logic [7:0] q[$];
   bit         routing, forwarding, discarding;
   logic [3:0] route_code;
   logic [7:0] exp_flit_out;
   bit         exp_valid, exp_credit;
   int         drops;

   function automatic logic [4:0] onehot(logic [3:0] code);
      case (code)
         4'd1:    return 5'b00001;
         4'd2:    return 5'b00010;
         4'd3:    return 5'b10000;
         4'd4:    return 5'b00100;
         4'd5:    return 5'b01000;
         default: return 5'b00000;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(bit v, logic [7:0] f, logic [3:0] p, bit g, bit r);
      logic [7:0] head;
      logic [1:0] t;
      bit popped, fwd, last, start;
      int had;
      if (r) begin
         q.delete();
         routing = 0; forwarding = 0; discarding = 0;
         route_code = '0; exp_flit_out = '0; exp_valid = 0; exp_credit = 0;
         drops = 0;
         return;
      end
      had   = q.size();
      head  = (had > 0) ? q[0] : 8'h00;
      t     = head[7:6];
      last  = (t == 2'b01) || (t == 2'b11);
      start = (t == 2'b10) || (t == 2'b11);
      popped = 0; fwd = 0;
      if (forwarding) begin
         if (g && had > 0) begin
            popped = 1; fwd = 1;
            if (last) forwarding = 0;
         end
      end else if (discarding) begin
         if (had > 0) begin
            popped = 1;
            if (drops < 255) drops++;
            if (last) discarding = 0;
         end
      end else if (routing) begin
         routing    = 0;
         route_code = p;
         if (p >= 4'd1 && p <= 4'd5) forwarding = 1;
         else                        discarding = 1;
      end else if (had > 0) begin
         if (start) routing = 1;
         else begin
            popped = 1;
            if (drops < 255) drops++;
         end
      end
      if (popped) void'(q.pop_front());
      if (v && (had < DEPTH || popped)) q.push_back(f);
      exp_valid  = fwd;
      exp_credit = popped;
      if (fwd) exp_flit_out = head;
   endtask

   task automatic check_all();
      chk("req_out", 32'(bus.req_out), 32'(forwarding ? onehot(route_code) : 5'b0));
      chk("route_flit", 32'(bus.route_flit), 32'(routing ? q[0] : 8'h00));
      chk("flit_out_valid", 32'(bus.flit_out_valid), 32'(exp_valid));
      if (exp_valid) chk("flit_out", 32'(bus.flit_out), 32'(exp_flit_out));
      chk("credit_out", 32'(bus.credit_out), 32'(exp_credit));
      chk("count", 32'(dut.count), 32'(q.size()));
`ifdef INPUT_PORT_DROP_CNT_EN
      chk("drop_cnt", 32'(bus.drop_cnt), 32'(drops));
`endif
   endtask

   task automatic cycle(bit v, logic [7:0] f, logic [3:0] p, bit g, bit r);
      bus.flit_in_valid = v;
      bus.flit_in       = f;
      bus.port_num_in   = p;
      bus.grant_in      = g;
      rst_n             = !r;
      model_step(v, f, p, g, r);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int credits, valids, reqs;
      logic [7:0] f;
      logic [3:0] p;

      cycle(0, 8'h00, 4'd0, 0, 1);
      cycle(0, 8'h00, 4'd0, 0, 1);
      chk("reset_req", 32'(bus.req_out), 32'd0);
      chk("reset_valid", 32'(bus.flit_out_valid), 32'd0);
      chk("reset_flit_out", 32'(bus.flit_out), 32'd0);

      // header latency: head visible, ROUTE, then request
      cycle(1, 8'h83, 4'd2, 0, 0);
      cycle(0, 8'h00, 4'd2, 0, 0);
      chk("d_route_flit", 32'(bus.route_flit), 32'h83);
      cycle(0, 8'h00, 4'd2, 0, 0);
      chk("d_req_e", 32'(bus.req_out), 32'b00010);

      // three-flit packet with grant held
      cycle(0, 8'h00, 4'd0, 0, 1);
      credits = 0;
      cycle(1, 8'h83, 4'd2, 1, 0); credits += int'(bus.credit_out);
      cycle(1, 8'h05, 4'd2, 1, 0); credits += int'(bus.credit_out);
      cycle(1, 8'h46, 4'd2, 1, 0); credits += int'(bus.credit_out);
      cycle(0, 8'h00, 4'd2, 1, 0); credits += int'(bus.credit_out);
      chk("d_out0", 32'(bus.flit_out), 32'h83);
      cycle(0, 8'h00, 4'd2, 1, 0); credits += int'(bus.credit_out);
      chk("d_out1", 32'(bus.flit_out), 32'h05);
      cycle(0, 8'h00, 4'd2, 1, 0); credits += int'(bus.credit_out);
      chk("d_out2", 32'(bus.flit_out), 32'h46);
      chk("d_req_after_tail", 32'(bus.req_out), 32'd0);
      cycle(0, 8'h00, 4'd2, 1, 0); credits += int'(bus.credit_out);
      chk("d_credits3", 32'(credits), 32'd3);

      // overflow: fifth flit dropped while grant is withheld
      cycle(0, 8'h00, 4'd0, 0, 1);
      credits = 0;
      cycle(1, 8'h83, 4'd2, 0, 0); credits += int'(bus.credit_out);
      cycle(1, 8'h05, 4'd2, 0, 0); credits += int'(bus.credit_out);
      cycle(1, 8'h05, 4'd2, 0, 0); credits += int'(bus.credit_out);
      cycle(1, 8'h46, 4'd2, 0, 0); credits += int'(bus.credit_out);
      cycle(1, 8'h07, 4'd2, 0, 0); credits += int'(bus.credit_out);
      chk("d_full_count", 32'(dut.count), 32'd4);
      chk("d_full_credits", 32'(credits), 32'd0);
      valids = 0;
      for (int i = 0; i < 7; i++) begin
         cycle(0, 8'h00, 4'd2, 1, 0);
         valids += int'(bus.flit_out_valid);
      end
      chk("d_drained", 32'(valids), 32'd4);

      // stray body flit at the head is discarded
      cycle(0, 8'h00, 4'd0, 0, 1);
      cycle(1, 8'h11, 4'd2, 0, 0);
      cycle(0, 8'h00, 4'd2, 0, 0);
      chk("d_discard_credit", 32'(bus.credit_out), 32'd1);
`ifdef INPUT_PORT_DROP_CNT_EN
      chk("d_drop_one", 32'(bus.drop_cnt), 32'd1);
`endif

      // unroutable packet drains silently
      cycle(0, 8'h00, 4'd0, 0, 1);
      credits = 0; valids = 0; reqs = 0;
      cycle(1, 8'h83, 4'd0, 1, 0);
      cycle(1, 8'h05, 4'd0, 1, 0);
      cycle(1, 8'h46, 4'd0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 8'h00, 4'd0, 1, 0);
         credits += int'(bus.credit_out);
         valids  += int'(bus.flit_out_valid);
         reqs    += int'(bus.req_out != 5'b0);
      end
      chk("d_drain_credits", 32'(credits), 32'd3);
      chk("d_drain_valid", 32'(valids), 32'd0);
      chk("d_drain_req", 32'(reqs), 32'd0);

      // reset in ACTIVE with two flits buffered
      cycle(0, 8'h00, 4'd0, 0, 1);
      cycle(1, 8'h83, 4'd4, 0, 0);
      cycle(1, 8'h05, 4'd4, 0, 0);
      cycle(0, 8'h00, 4'd4, 0, 0);
      chk("d_pre_rst_req", 32'(bus.req_out), 32'b00100);
      chk("d_pre_rst_count", 32'(dut.count), 32'd2);
      cycle(0, 8'h00, 4'd4, 1, 1);
      chk("d_rst_count", 32'(dut.count), 32'd0);
      chk("d_rst_req", 32'(bus.req_out), 32'd0);
      chk("d_rst_flit_out", 32'(bus.flit_out), 32'd0);
      cycle(0, 8'h00, 4'd4, 1, 0);
      chk("d_rst_no_credit", 32'(bus.credit_out), 32'd0);

      // long run of stray body flits saturates the drop count
      for (int i = 0; i < 262; i++) cycle(1, 8'h00, 4'd1, 0, 0);
`ifdef INPUT_PORT_DROP_CNT_EN
      chk("d_drop_sat", 32'(bus.drop_cnt), 32'd255);
`endif

      // random traffic
      cycle(0, 8'h00, 4'd0, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         f = 8'($urandom);
         if ($urandom_range(0, 9) < 7) f[7:6] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
         else                          f[7:6] = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
         p = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 5)) : 4'($urandom_range(0, 15));
         cycle($urandom_range(0, 9) < 6, f, p, $urandom_range(0, 9) < 7,
               $urandom_range(0, 499) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/input_port_ctrl.md
INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, 4, flit FIFO depth in flits (power of two, at least 2).
REQ-002 SHALL have parameter FLIT_W, 8, flit width; bits [7:6] are the type (10 header, 00 body, 01 tail, 11 single-flit); header bits [3:0] are the destination {y[1:0], x[1:0]}.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flit_in  input  FLIT_W  flit from the upstream link.
REQ-006 SHALL have port flit_in_valid  input  1  flit_in is valid this cycle.
REQ-007 SHALL have port credit_out  output  1  one-cycle pulse returning one buffer credit upstream.
REQ-008 SHALL have port route_flit  output  FLIT_W  header flit presented to the route-compute stage.
REQ-009 SHALL have port port_num_in  input  4  route-compute result: 1=L, 2=E, 3=N, 4=W, 5=S.
REQ-010 SHALL have port req_out  output  5  one-hot switch request: [0]=L, [1]=E, [2]=W, [3]=S, [4]=N.
REQ-011 SHALL have port grant_in  input  1  switch grant for this port.
REQ-012 SHALL have port flit_out  output  FLIT_W  flit to the crossbar.
REQ-013 SHALL have port flit_out_valid  output  1  flit_out is valid.

Function
REQ-014 SHALL accept a push when flit_in_valid=1 and either count<DEPTH or a pop occurs in the same cycle; otherwise the flit SHALL be ignored with no state change.
REQ-015 SHALL keep the FIFO in circular order with read/write pointers wrapping modulo DEPTH and count in the range 0..DEPTH.
REQ-016 SHALL implement the FSM states IDLE, ROUTE, ACTIVE and DRAIN.
REQ-017 In IDLE with a non-empty FIFO: a head of type 10 or 11 SHALL cause a transition to ROUTE; any other head type SHALL be popped and discarded while the state stays IDLE.
REQ-018 In ROUTE, route_flit SHALL equal the FIFO head, and on the next edge port_num_in SHALL be latched into route_reg.
REQ-019 The ROUTE exit SHALL go to ACTIVE when the latched code is 1-5, otherwise to DRAIN.
REQ-020 route_flit SHALL be 0 in all states other than ROUTE.
REQ-021 In ACTIVE, req_out SHALL be the one-hot decode of route_reg, held for the whole packet.
REQ-022 In ACTIVE, grant_in=1 with a non-empty FIFO SHALL pop the head.
REQ-023 In ACTIVE, popping a flit of type 01 or 11 SHALL return the FSM to IDLE, and req_out SHALL be 0 from the next cycle.
REQ-024 In ACTIVE with an empty FIFO, no pop SHALL occur and req_out SHALL stay asserted.
REQ-025 In DRAIN, the FSM SHALL pop one flit per cycle while the FIFO is non-empty, drive no request, drive no flit_out_valid, and return to IDLE after popping a tail or single-flit.
REQ-026 On an ACTIVE pop, flit_out and flit_out_valid SHALL be registered, giving one cycle of latency from the grant to valid output.
REQ-027 flit_out_valid SHALL be 0 in any cycle without an ACTIVE pop.
REQ-028 credit_out SHALL pulse, registered, the cycle after every pop, including IDLE discards and DRAIN pops.
REQ-029 Minimum header latency SHALL be: push at edge t, head visible after t, ROUTE entered at t+1, req_out asserted after t+2.
REQ-030 A simultaneous push and pop SHALL leave count unchanged, including when the FIFO is full and when it is empty.

Reset
REQ-031 With rst_n=0 at a rising edge, the block SHALL go to IDLE with count=0, both pointers=0, route_reg=0, and outputs req_out=0, flit_out=0, flit_out_valid=0, credit_out=0, route_flit=0.
REQ-032 A reset mid-packet SHALL discard all buffered flits without issuing any credit pulses.
REQ-033 FIFO storage contents SHALL NOT require reset.

Configuration
REQ-034 When INPUT_PORT_DROP_CNT_EN is defined, the block SHALL add an output drop_cnt [7:0]: a saturating (at 255) count of flits discarded in IDLE or DRAIN, cleared by reset.
REQ-035 When INPUT_PORT_DROP_CNT_EN is undefined, the drop_cnt port and its logic SHALL be absent, with identical behaviour otherwise.

Verification
REQ-036 Reset release, then push header 8'h83 (dest x=3, y=0) with route-compute returning 2 -> req_out=5'b00010 two cycles after the head is visible; route_flit=8'h83 during ROUTE.
REQ-037 Header 8'h83, body 8'h05, tail 8'h46 with grant_in held at 1 -> flit_out shows 83, 05, 46 on consecutive cycles; three credit_out pulses; req_out=0 after the tail.
REQ-038 Push 5 flits into an empty FIFO (DEPTH=4) with grant_in=0 -> 5th flit dropped; count=4; no credit_out; a drained stream shows 4 flits only.
REQ-039 Head body flit 8'h11 in IDLE -> discarded with one credit_out pulse; drop_cnt=1 when the macro is enabled.
REQ-040 Header with port_num_in=4'd0 followed by body and tail -> DRAIN pops 3 flits, no req_out, no flit_out_valid, then IDLE.
REQ-041 Assert rst_n=0 for one cycle while in ACTIVE with 2 flits buffered -> next cycle IDLE, count=0, all outputs 0.
